// File: rtl/scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
//   state_e      : FSM encoding (IDLE / SCAN / BLANK)
//   NCH, SELW    : channel count and decoder address width
//   first_set()  : lowest set bit of a channel mask
package scan_pkg;

  localparam int unsigned NCH  = 8;
  localparam int unsigned SELW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_e;

  // Lowest set bit of m; returns 0 when m is empty (callers never rely on it).
  function automatic logic [SELW-1:0] first_set(input logic [NCH-1:0] m);
    logic [SELW-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && m[i]) begin
        r     = SELW'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Round-robin next-channel search.
//   cur_sel  in  SELW  current pointer
//   mask     in  NCH   per-channel enable
//   nxt_sel  out SELW  first enabled channel after cur_sel, wrapping,
//                      ending at cur_sel itself
//   wrap     out 1     nxt_sel <= cur_sel (pointer went round)
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [SELW-1:0] cur_sel,
  input  logic [NCH-1:0]  mask,
  output logic [SELW-1:0] nxt_sel,
  output logic            wrap
);

  logic [SELW-1:0] idx;
  logic            found;

  always_comb begin
    nxt_sel = cur_sel;
    idx     = '0;
    found   = 1'b0;
    // i = NCH lands back on cur_sel through natural address wrap.
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = cur_sel + SELW'(i);
      if (!found && mask[idx]) begin
        nxt_sel = idx;
        found   = 1'b1;
      end
    end
  end

  assign wrap = (nxt_sel <= cur_sel);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for the 3-to-8 display decoder.
//   clk, rst_n   clock, synchronous active-low reset
//   EN           scan enable (0 forces IDLE)
//   in_mask      per-channel enable, sampled at channel advance
//   out_sel      decoder address
//   out_dec_en   decoder enable
//   out_Y        registered one-hot of out_sel, gated by out_dec_en
//   out_frame    one-cycle pulse in the first cycle of a wrapped pointer
module decoder_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EN,
  input  logic [NCH-1:0]  in_mask,
  output logic [SELW-1:0] out_sel,
  output logic            out_dec_en,
  output logic [NCH-1:0]  out_Y,
  output logic            out_frame
);

  localparam int unsigned DB_MAX  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_MAX = (DB_MAX > 2) ? DB_MAX : 2;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            dec_en_q, dec_en_d;
  logic [NCH-1:0]  y_q, y_d;
  logic            frame_q, frame_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [SELW-1:0] nxt_sel;
  logic            nxt_wrap;

  scan_next_sel u_next (
    .cur_sel (sel_q),
    .mask    (in_mask),
    .nxt_sel (nxt_sel),
    .wrap    (nxt_wrap)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dec_en_d = dec_en_q;
    y_d      = y_q;
    frame_d  = 1'b0;
    cnt_d    = cnt_q;

    if (!EN || (in_mask == '0)) begin
      state_d  = IDLE;
      sel_d    = '0;
      dec_en_d = 1'b0;
      y_d      = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = SCAN;
          sel_d    = first_set(in_mask);
          dec_en_d = 1'b1;
          y_d      = NCH'(1) << first_set(in_mask);
          cnt_d    = '0;
        end
        SCAN: begin
          if (cnt_q == DW_LAST) begin
            sel_d   = nxt_sel;
            frame_d = nxt_wrap;
            cnt_d   = '0;
            if (BLANK_CYCLES == 0) begin
              state_d  = SCAN;
              dec_en_d = 1'b1;
              y_d      = NCH'(1) << nxt_sel;
            end else begin
              state_d  = BLANK;
              dec_en_d = 1'b0;
              y_d      = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BL_LAST) begin
            state_d  = SCAN;
            dec_en_d = 1'b1;
            y_d      = NCH'(1) << sel_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d  = IDLE;
          sel_d    = '0;
          dec_en_d = 1'b0;
          y_d      = '0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      dec_en_q <= 1'b0;
      y_q      <= '0;
      frame_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      dec_en_q <= dec_en_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_sel    = sel_q;
  assign out_dec_en = dec_en_q;
  assign out_Y      = y_q;
  assign out_frame  = frame_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, en1;
  logic [7:0] mask0, mask1;

  logic [2:0] sel0, sel1;
  logic       de0, de1;
  logic [7:0] y0, y1;
  logic       fr0, fr1;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .EN(en0), .in_mask(mask0),
    .out_sel(sel0), .out_dec_en(de0), .out_Y(y0), .out_frame(fr0)
  );

  decoder_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .EN(en1), .in_mask(mask1),
    .out_sel(sel1), .out_dec_en(de1), .out_Y(y1), .out_frame(fr1)
  );

  typedef struct {
    string      tag;
    bit         which;
    logic [2:0] sel;
    logic       de;
    logic [7:0] y;
    logic       fr;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input bit w, input logic [2:0] s,
                      input logic de, input logic f);
    exp_t e;
    logic [7:0] one;
    one     = 8'h01;
    e.tag   = tag;
    e.which = w;
    e.sel   = s;
    e.de    = de;
    e.y     = de ? (one << s) : 8'h00;
    e.fr    = f;
    q.push_back(e);
  endtask

  task automatic push_lit(input string tag, input bit w, input logic [2:0] ch,
                          input logic f_first, input int n = 4);
    for (int i = 0; i < n; i++) push(tag, w, ch, 1'b1, (i == 0) ? f_first : 1'b0);
  endtask

  task automatic push_idle(input string tag, input bit w, input int n);
    for (int i = 0; i < n; i++) push(tag, w, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    exp_t e;
    logic [12:0] obs, expv;
    @(posedge clk);
    #1;
    e    = q.pop_front();
    obs  = e.which ? {sel1, de1, y1, fr1} : {sel0, de0, y0, fr0};
    expv = {e.sel, e.de, e.y, e.fr};
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed sel=%0d en=%b y=%h frame=%b, expected sel=%0d en=%b y=%h frame=%b",
             e.tag, obs[12:10], obs[9], obs[8:1], obs[0],
             expv[12:10], expv[9], expv[8:1], expv[0]);
    end
  endtask

  task automatic run_all();
    while (q.size() > 0) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    en0   = 1'b1;
    mask0 = 8'hFF;
    en1   = 1'b0;
    mask1 = 8'h00;

    // Reset held with scan requested: everything stays dark.
    push_idle("reset", 1'b0, 3);
    run_all();

    // Full mask round: 0..7 then back to 0, frame only on 7->0.
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      push_lit("full_scan", 1'b0, 3'(c), 1'b0);
      push("full_blank", 1'b0, 3'(c + 1), 1'b0, (c == 7));
    end
    push_lit("full_scan", 1'b0, 3'd0, 1'b0);
    run_all();

    en0 = 1'b0;
    push_idle("en_drop", 1'b0, 1);
    run_all();

    // Sparse mask 1001_0100: 2,4,7,2.
    en0   = 1'b1;
    mask0 = 8'b1001_0100;
    push_lit("sparse", 1'b0, 3'd2, 1'b0);
    push("sparse_blank", 1'b0, 3'd4, 1'b0, 1'b0);
    push_lit("sparse", 1'b0, 3'd4, 1'b0);
    push("sparse_blank", 1'b0, 3'd7, 1'b0, 1'b0);
    push_lit("sparse", 1'b0, 3'd7, 1'b0);
    push("sparse_wrap", 1'b0, 3'd2, 1'b0, 1'b1);
    push_lit("sparse", 1'b0, 3'd2, 1'b0);
    run_all();

    mask0 = 8'h00;
    push_idle("mask_zero", 1'b0, 2);
    run_all();

    // Single channel 5: frame every 5 cycles.
    mask0 = 8'h20;
    push_lit("single", 1'b0, 3'd5, 1'b0);
    push("single_blank", 1'b0, 3'd5, 1'b0, 1'b1);
    push_lit("single", 1'b0, 3'd5, 1'b0);
    push("single_blank", 1'b0, 3'd5, 1'b0, 1'b1);
    push_lit("single", 1'b0, 3'd5, 1'b0, 1);
    run_all();
    mask0 = 8'h00;
    push_idle("mask_zero", 1'b0, 1);
    run_all();

    // Mask 0F, clear bit 1 during channel 1's dwell.
    mask0 = 8'h0F;
    push_lit("mchg", 1'b0, 3'd0, 1'b0);
    push("mchg_blank", 1'b0, 3'd1, 1'b0, 1'b0);
    push_lit("mchg", 1'b0, 3'd1, 1'b0, 1);
    run_all();
    mask0 = 8'h0D;
    push_lit("mchg_hold", 1'b0, 3'd1, 1'b0, 3);
    push("mchg_blank", 1'b0, 3'd2, 1'b0, 1'b0);
    push_lit("mchg", 1'b0, 3'd2, 1'b0, 2);
    run_all();
    mask0 = 8'h00;
    push_idle("mchg_zero", 1'b0, 1);
    run_all();

    // EN drop during channel 6, re-enable restarts at first(C0)=6.
    en0   = 1'b1;
    mask0 = 8'hC0;
    push_lit("endrop", 1'b0, 3'd6, 1'b0);
    push("endrop_blank", 1'b0, 3'd7, 1'b0, 1'b0);
    push_lit("endrop", 1'b0, 3'd7, 1'b0);
    push("endrop_wrap", 1'b0, 3'd6, 1'b0, 1'b1);
    push_lit("endrop", 1'b0, 3'd6, 1'b0, 2);
    run_all();
    en0 = 1'b0;
    push_idle("endrop_idle", 1'b0, 2);
    run_all();
    en0 = 1'b1;
    push_lit("restart", 1'b0, 3'd6, 1'b0);
    push("restart_blank", 1'b0, 3'd7, 1'b0, 1'b0);
    push_lit("restart", 1'b0, 3'd7, 1'b0, 2);
    run_all();
    // Drop during channel 7: restart must not resume at the old pointer.
    en0 = 1'b0;
    push_idle("endrop7_idle", 1'b0, 1);
    run_all();
    en0 = 1'b1;
    push_lit("restart7", 1'b0, 3'd6, 1'b0, 2);
    run_all();

    // Reset mid-dwell.
    rst_n = 1'b0;
    push_idle("rst_mid", 1'b0, 2);
    run_all();
    rst_n = 1'b1;
    push_lit("rst_resume", 1'b0, 3'd6, 1'b0, 1);
    run_all();

    // Zero blanking on the second instance.
    en1   = 1'b1;
    mask1 = 8'h03;
    push_lit("noblank", 1'b1, 3'd0, 1'b0);
    push_lit("noblank", 1'b1, 3'd1, 1'b0);
    push_lit("noblank", 1'b1, 3'd0, 1'b1);
    push_lit("noblank", 1'b1, 3'd1, 1'b0);
    run_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
